// File: rtl/seg7_pkg.sv
// Shared types, the hex-to-segment table and a decode helper for the seven-segment scan controller.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam seg_t SEG7_HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble, input logic active_low);
    seg_t w_pat;
    w_pat = SEG7_HEX_LUT[nibble];
    return active_low ? w_pat : ~w_pat;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the scan controller: digit data and controls in, seg/dp/an pins and frame pulse out.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
  logic                    freeze;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output data, dp_in, digit_en, brightness, freeze,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  data, dp_in, digit_en, brightness, freeze,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, polarity fixed at elaboration.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex_to_seg(i_nibble, ACTIVE_LOW);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with PWM brightness and frame-synchronous shadowing.
// Optional leading-zero suppression at frame capture is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV_LOG2  = 14,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam seg_t                  SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

  logic [SCAN_DIV_LOG2-1:0] r_slot_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0]  r_shadow_data;
  logic [NUM_DIGITS-1:0]    r_shadow_dp;
  logic [NUM_DIGITS-1:0]    r_shadow_en;
  logic [NUM_DIGITS-1:0]    r_shadow_zs;
  logic                     r_frame_done;
  logic [NUM_DIGITS-1:0]    r_an;
  seg_t                     r_seg;
  logic                     r_dp;

  logic [3:0]            w_nib [NUM_DIGITS];
  logic [3:0]            w_phase;
  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic                  w_lit;
  seg_t                  w_seg_dec;
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic [NUM_DIGITS-1:0] w_an_active;
  logic                  w_dp_active;
  logic [NUM_DIGITS-1:0] w_cap_en;
  logic [NUM_DIGITS-1:0] w_cap_zs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_shadow_data[4*gi +: 4];
    end
  endgenerate

  assign w_phase      = r_slot_cnt[SCAN_DIV_LOG2-1 -: 4];
  assign w_slot_wrap  = &r_slot_cnt;
  assign w_frame_wrap = w_slot_wrap && (r_idx == LAST_IDX);

  // Phase 0 is a guard band so the previous digit's segments never bleed into the next anode.
  assign w_lit = r_shadow_en[r_idx] && (w_phase != 4'd0) && (w_phase <= bus.brightness);

  seg7_hex_decode #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_dec (
    .i_nibble(w_nib[r_idx]),
    .o_seg   (w_seg_dec)
  );

  assign w_an_onehot = NUM_DIGITS'(1) << r_idx;
  assign w_an_active = AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
  assign w_dp_active = SEG_ACTIVE_LOW ? ~r_shadow_dp[r_idx] : r_shadow_dp[r_idx];

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0]      w_top;
  logic [NUM_DIGITS-1:0] w_keep;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.data[4*i +: 4] != 4'd0) w_top = IDX_W'(i);
    end
  end

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_keep
      assign w_keep[gi] = (IDX_W'(gi) <= w_top);
    end
  endgenerate

  // A suppressed digit with a dp request stays enabled but shows only the dp.
  assign w_cap_en = bus.digit_en & (w_keep | bus.dp_in);
  assign w_cap_zs = ~w_keep;
`else
  assign w_cap_en = bus.digit_en;
  assign w_cap_zs = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_shadow_en   <= '0;
      r_shadow_zs   <= '0;
      r_frame_done  <= 1'b0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= DP_OFF;
    end else begin
      r_slot_cnt <= r_slot_cnt + SCAN_DIV_LOG2'(1);
      if (w_slot_wrap) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
      r_frame_done <= w_frame_wrap;
      if (w_frame_wrap && !bus.freeze) begin
        r_shadow_data <= bus.data;
        r_shadow_dp   <= bus.dp_in;
        r_shadow_en   <= w_cap_en;
        r_shadow_zs   <= w_cap_zs;
      end
      r_an  <= w_lit ? w_an_active : AN_OFF;
      r_seg <= (w_lit && !r_shadow_zs[r_idx]) ? w_seg_dec : SEG_OFF;
      r_dp  <= w_lit ? w_dp_active : DP_OFF;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
